// File: rtl/idli_pkg.sv
// Shared types and field decode for the idli instruction-stream decoder.
package idli_pkg;

  localparam int         DCD_WORD_W = 16;
  localparam logic [2:0] GREG_IMM   = 3'd7;
  localparam logic [1:0] PT         = 2'd3;

  typedef enum logic {
    ST_INSTR = 1'b0,
    ST_IMM   = 1'b1
  } dcd_state_t;

  typedef struct packed {
    logic [3:0]  opc;
    logic [1:0]  p;
    logic [1:0]  q;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [2:0]  c;
    logic        nop;
    logic [15:0] imm;
    logic        imm_vld;
  } dcd_op_t;

  // Bit 11 of the word carries no field, so only the used slices are passed in.
  function automatic dcd_op_t dcd_decode(input logic [3:0] opc, input logic [10:0] lo);
    dcd_op_t op;
    op         = '0;
    op.opc     = opc;
    op.p       = (opc == 4'd0) ? PT : lo[10:9];
    op.a       = {lo[8], lo[7:6]};
    op.q       = lo[7:6];
    op.b       = lo[5:3];
    op.c       = lo[2:0];
    op.nop     = (opc == 4'd0) && !lo[8];
    return op;
  endfunction

endpackage

// File: rtl/idli_dcd_fifo_m.sv
// Output queue of decoded ops; flush and reset clear it, head comes straight from storage.
module idli_dcd_fifo_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_gck,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  dcd_op_t                    i_data,
  input  logic                       i_pop,
  output dcd_op_t                    o_data,
  output logic                       o_vld,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  dcd_op_t       mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign push_ok = i_push && (cnt_q != CW'(DEPTH));
  assign pop_ok  = i_pop && (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + CW'(1);
    else if (pop_ok && !push_ok) cnt_d = cnt_q - CW'(1);
    if (i_flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_gck) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is cleared on reset so the head reads all-zero out of reset.
  always_ff @(posedge i_gck) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok && !i_flush) begin
      mem_q[wr_q] <= i_data;
    end
  end

  assign o_data = mem_q[rd_q];
  assign o_vld  = (cnt_q != '0);
  assign o_cnt  = cnt_q;

endmodule

// File: rtl/idli_decode_stream_m.sv
// Assembles LANE_W-bit beats into 16b words, decodes them and queues ops with optional immediates.
// IDLI_DECODE_NOP_DROP_EN: when defined, NOP words are discarded instead of queued.
module idli_decode_stream_m
  import idli_pkg::*;
#(
  parameter int LANE_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       i_dcd_gck,
  input  logic                       i_dcd_rst,
  input  logic [LANE_W-1:0]          i_dcd_enc,
  input  logic                       i_dcd_enc_vld,
  output logic                       o_dcd_enc_rdy,
  input  logic                       i_dcd_flush,
  output dcd_op_t                    o_dcd_op,
  output logic                       o_dcd_op_vld,
  input  logic                       i_dcd_op_rdy,
  output logic [$clog2(DEPTH+1)-1:0] o_dcd_cnt
);

  localparam int BEATS = DCD_WORD_W / LANE_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (BEATS > 1) ? (DCD_WORD_W - LANE_W) : 1;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  dcd_state_t          state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [PW-1:0]       word_q, word_d;
  dcd_op_t             held_q, held_d;
  logic [DCD_WORD_W-1:0] word_nxt;
  dcd_op_t             dec, push_op;
  logic                acc, last, push;

  // word_q keeps only the beats already received; the current beat completes the word.
  if (BEATS > 1) begin : g_shift
    assign word_nxt = {word_q, i_dcd_enc};
  end else begin : g_single
    assign word_nxt = DCD_WORD_W'(i_dcd_enc);
  end

  assign o_dcd_enc_rdy = (o_dcd_cnt < CW'(DEPTH)) && !i_dcd_flush && !i_dcd_rst;
  assign acc  = i_dcd_enc_vld && o_dcd_enc_rdy;
  assign last = (beat_q == LAST_BEAT);
  assign dec  = dcd_decode(word_nxt[15:12], word_nxt[10:0]);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    word_d  = word_q;
    held_d  = held_q;
    push    = 1'b0;
    push_op = dec;
    if (acc) begin
      beat_d = last ? '0 : beat_q + BW'(1);
      word_d = word_nxt[PW-1:0];
    end
    if (acc && last) begin
      case (state_q)
        ST_INSTR: begin
          if (!dec.nop && (dec.c == GREG_IMM)) begin
            held_d  = dec;
            state_d = ST_IMM;
          end else begin
`ifdef IDLI_DECODE_NOP_DROP_EN
            push = !dec.nop;
`else
            push = 1'b1;
`endif
          end
        end
        ST_IMM: begin
          push_op         = held_q;
          push_op.imm     = word_nxt;
          push_op.imm_vld = 1'b1;
          push            = 1'b1;
          state_d         = ST_INSTR;
        end
      endcase
    end
    if (i_dcd_flush) begin
      state_d = ST_INSTR;
      beat_d  = '0;
      held_d  = '0;
      push    = 1'b0;
    end
  end

  always_ff @(posedge i_dcd_gck) begin
    if (i_dcd_rst) begin
      state_q <= ST_INSTR;
      beat_q  <= '0;
      word_q  <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      held_q  <= held_d;
    end
  end

  idli_dcd_fifo_m #(.DEPTH(DEPTH)) u_fifo (
    .i_gck   (i_dcd_gck),
    .i_rst   (i_dcd_rst),
    .i_flush (i_dcd_flush),
    .i_push  (push),
    .i_data  (push_op),
    .i_pop   (i_dcd_op_rdy),
    .o_data  (o_dcd_op),
    .o_vld   (o_dcd_op_vld),
    .o_cnt   (o_dcd_cnt)
  );

endmodule

// File: tb/tb_idli_decode_stream_m.sv
// Bench for idli_decode_stream_m: table of words plus hand sequences, scoreboard on the op output.
module tb_idli_decode_stream_m;
  import idli_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, enc_vld, enc_rdy, op_vld, op_rdy;
  logic [3:0] enc;
  logic [2:0] cnt;
  dcd_op_t    op;

  logic       vld8, rdy8, opv8, oprdy8, flush8;
  logic [7:0] enc8;
  logic [2:0] cnt8;
  dcd_op_t    op8;

  idli_decode_stream_m #(.LANE_W(4), .DEPTH(4)) u_dut (
    .i_dcd_gck(clk), .i_dcd_rst(rst), .i_dcd_enc(enc), .i_dcd_enc_vld(enc_vld),
    .o_dcd_enc_rdy(enc_rdy), .i_dcd_flush(flush), .o_dcd_op(op), .o_dcd_op_vld(op_vld),
    .i_dcd_op_rdy(op_rdy), .o_dcd_cnt(cnt)
  );

  idli_decode_stream_m #(.LANE_W(8), .DEPTH(4)) u_dut8 (
    .i_dcd_gck(clk), .i_dcd_rst(rst), .i_dcd_enc(enc8), .i_dcd_enc_vld(vld8),
    .o_dcd_enc_rdy(rdy8), .i_dcd_flush(flush8), .o_dcd_op(op8), .o_dcd_op_vld(opv8),
    .i_dcd_op_rdy(oprdy8), .o_dcd_cnt(cnt8)
  );

  int n_vec = 0;
  int n_bad = 0;
  dcd_op_t exp_q[$];

  typedef struct {
    logic [15:0] w;
    logic [15:0] iw;
    logic        hi;
    dcd_op_t     e;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic dcd_op_t mk(logic [3:0] opc, logic [1:0] p, logic [1:0] q, logic [2:0] a,
                                 logic [2:0] b, logic [2:0] c, logic nop, logic [15:0] imm,
                                 logic iv);
    dcd_op_t o;
    o.opc = opc; o.p = p; o.q = q; o.a = a; o.b = b; o.c = c;
    o.nop = nop; o.imm = imm; o.imm_vld = iv;
    return o;
  endfunction

  function automatic logic keep(dcd_op_t e);
`ifdef IDLI_DECODE_NOP_DROP_EN
    return !e.nop;
`else
    return (e.opc == e.opc);
`endif
  endfunction

  // Inputs change 1 time unit after the rising edge.
  task automatic send_beat(input logic [3:0] v);
    int n = 0;
    enc = v;
    enc_vld = 1'b1;
    #1;
    while (!enc_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!enc_rdy) chk("beat_rdy_timeout", 64'(enc_rdy), 64'd1);
    @(posedge clk); #1;
    enc_vld = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) send_beat(w[i*4 +: 4]);
  endtask

  task automatic send8(input logic [7:0] v);
    int n = 0;
    enc8 = v;
    vld8 = 1'b1;
    #1;
    while (!rdy8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy8) chk("beat8_rdy_timeout", 64'(rdy8), 64'd1);
    @(posedge clk); #1;
    vld8 = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    op_rdy = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) chk({nm, "_drain_vld"}, 64'(op_vld), 64'd1);
    chk({nm, "_drain_cnt"}, 64'(cnt), 64'd0);
    chk({nm, "_drain_vld0"}, 64'(op_vld), 64'd0);
  endtask

  // Scoreboard: every accepted output is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && !flush && op_vld && op_rdy) begin
      if (exp_q.size() == 0) chk("unexpected_op_vld", 64'(op_vld), 64'd0);
      else chk("op", 64'(op), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    tbl[0] = '{16'hC123, 16'h0000, 1'b0, mk(4'hC, 2'd0, 2'd0, 3'd4, 3'd4, 3'd3, 1'b0, 16'h0000, 1'b0)};
    tbl[1] = '{16'hC127, 16'hBEEF, 1'b1, mk(4'hC, 2'd0, 2'd0, 3'd4, 3'd4, 3'd7, 1'b0, 16'hBEEF, 1'b1)};
    tbl[2] = '{16'h0000, 16'h0000, 1'b0, mk(4'h0, 2'd3, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0000, 1'b0)};
    tbl[3] = '{16'h0100, 16'h0000, 1'b0, mk(4'h0, 2'd3, 2'd0, 3'd4, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0)};
    tbl[4] = '{16'h5ABC, 16'h0000, 1'b0, mk(4'h5, 2'd1, 2'd2, 3'd2, 3'd7, 3'd4, 1'b0, 16'h0000, 1'b0)};
    tbl[5] = '{16'h0107, 16'h1234, 1'b1, mk(4'h0, 2'd3, 2'd0, 3'd4, 3'd0, 3'd7, 1'b0, 16'h1234, 1'b1)};
    tbl[6] = '{16'hF6C7, 16'h0000, 1'b1, mk(4'hF, 2'd3, 2'd3, 3'd3, 3'd0, 3'd7, 1'b0, 16'h0000, 1'b1)};
    tbl[7] = '{16'h0007, 16'h0000, 1'b0, mk(4'h0, 2'd3, 2'd0, 3'd0, 3'd0, 3'd7, 1'b1, 16'h0000, 1'b0)};
    tbl[8] = '{16'h3456, 16'h0000, 1'b0, mk(4'h3, 2'd2, 2'd1, 3'd1, 3'd2, 3'd6, 1'b0, 16'h0000, 1'b0)};

    rst = 1'b1; flush = 1'b0; enc_vld = 1'b0; enc = '0; op_rdy = 1'b0;
    vld8 = 1'b0; enc8 = '0; oprdy8 = 1'b0; flush8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enc_rdy", 64'(enc_rdy), 64'd0);
    chk("rst_op_vld", 64'(op_vld), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_op", 64'(op), 64'd0);
    chk("rst_op8", 64'(op8), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_enc_rdy", 64'(enc_rdy), 64'd1);

    // One-cycle latency from the final beat to op_vld.
    send_beat(4'hC); send_beat(4'h1); send_beat(4'h2);
    chk("lat_no_early_vld", 64'(op_vld), 64'd0);
    exp_q.push_back(tbl[0].e);
    send_beat(4'h3);
    chk("lat_vld", 64'(op_vld), 64'd1);
    chk("lat_cnt", 64'(cnt), 64'd1);
    chk("lat_head", 64'(op), 64'(tbl[0].e));
    drain("lat");

    for (int i = 0; i < 9; i++) begin
      if (keep(tbl[i].e)) exp_q.push_back(tbl[i].e);
      send_word(tbl[i].w);
      if (tbl[i].hi) send_word(tbl[i].iw);
    end
    drain("tbl");

    // Fill to DEPTH with the consumer stalled.
    op_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(mk(4'hA, 2'd0, 2'd0, 3'd0, 3'd0, 3'(k), 1'b0, 16'h0000, 1'b0));
      send_word(16'hA000 | 16'(k));
    end
    chk("full_cnt", 64'(cnt), 64'd4);
    chk("full_enc_rdy", 64'(enc_rdy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("full_head_stable", 64'(op), 64'(exp_q[0]));
    op_rdy = 1'b1;
    #1;
    chk("full_pop_enc_rdy", 64'(enc_rdy), 64'd0);
    @(posedge clk); #1;
    op_rdy = 1'b0;
    chk("pop1_cnt", 64'(cnt), 64'd3);
    chk("pop1_enc_rdy", 64'(enc_rdy), 64'd1);
    exp_q.push_back(mk(4'hA, 2'd0, 2'd0, 3'd0, 3'd0, 3'd5, 1'b0, 16'h0000, 1'b0));
    send_beat(4'hA); send_beat(4'h0); send_beat(4'h0);
    op_rdy = 1'b1;
    send_beat(4'h5);
    op_rdy = 1'b0;
    chk("pushpop_cnt", 64'(cnt), 64'd3);
    drain("full");

    // Flush mid-immediate with a queued entry.
    op_rdy = 1'b0;
    exp_q.push_back(mk(4'hA, 2'd0, 2'd0, 3'd0, 3'd0, 3'd1, 1'b0, 16'h0000, 1'b0));
    send_word(16'hA001);
    send_word(16'hC127);
    send_beat(4'hB); send_beat(4'hE);
    flush = 1'b1;
    #1;
    chk("flush_enc_rdy", 64'(enc_rdy), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    chk("flush_cnt", 64'(cnt), 64'd0);
    chk("flush_op_vld", 64'(op_vld), 64'd0);
    exp_q.push_back(mk(4'hD, 2'd0, 2'd0, 3'd0, 3'd2, 3'd2, 1'b0, 16'h0000, 1'b0));
    op_rdy = 1'b1;
    send_word(16'hD012);
    drain("flush");

    // Reset mid-word.
    send_beat(4'hC);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_cnt", 64'(cnt), 64'd0);
    exp_q.push_back(tbl[0].e);
    send_word(16'hC123);
    drain("midrst");

    // Byte lanes: the immediate arrives as two beats.
    send8(8'hC1); send8(8'h27);
    chk("l8_no_entry_vld", 64'(opv8), 64'd0);
    chk("l8_no_entry_cnt", 64'(cnt8), 64'd0);
    send8(8'hBE); send8(8'hEF);
    chk("l8_vld", 64'(opv8), 64'd1);
    chk("l8_cnt", 64'(cnt8), 64'd1);
    chk("l8_op", 64'(op8), 64'(tbl[1].e));
    oprdy8 = 1'b1;
    @(posedge clk); #1;
    oprdy8 = 1'b0;
    chk("l8_pop_cnt", 64'(cnt8), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/idli_decode_stream_m.md
IDLI_DECODE_STREAM_M -- requirements
Module: idli_decode_stream_m

Interface
REQ-001 SHALL have parameter LANE_W, default 4, encoding bits accepted per beat; legal values 4, 8, 16.
REQ-002 SHALL have parameter DEPTH, default 4, output queue entries; power of two, at least 2.
REQ-003 SHALL have port i_dcd_gck  in  1  the one clock; all state updates on its rising edge.
REQ-004 SHALL have port i_dcd_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_dcd_enc  in  LANE_W  encoding beat, most-significant beat of each 16b word first.
REQ-006 SHALL have port i_dcd_enc_vld  in  1  beat valid.
REQ-007 SHALL have port o_dcd_enc_rdy  out  1  beat accepted when vld and rdy are both high.
REQ-008 SHALL have port i_dcd_flush  in  1  discard partial word and all queued entries.
REQ-009 SHALL have port o_dcd_op  out  dcd_op_t  head queue entry.
REQ-010 SHALL have port o_dcd_op_vld  out  1  queue non-empty.
REQ-011 SHALL have port i_dcd_op_rdy  in  1  pop head when vld and rdy are both high.
REQ-012 SHALL have port o_dcd_cnt  out  $clog2(DEPTH+1)  queued entry count.

Function
REQ-013 SHALL assemble 16/LANE_W accepted beats into one 16b word enc[15:0]; a beat counter wraps to 0 after the last beat.
REQ-014 SHALL decode fields: opc=enc[15:12], p=enc[10:9], a={enc[8],enc[7:6]}, q=enc[7:6], b=enc[5:3], c=enc[2:0].
REQ-015 SHALL force p=PT when opc==0; SHALL set nop=1 when opc==0 and enc[8]==0.
REQ-016 SHALL operate an FSM with two states: ST_INSTR (collecting instruction beats) and ST_IMM (collecting immediate beats).
REQ-017 In ST_INSTR, a completed non-NOP word with c==7 SHALL be held and SHALL move the FSM to ST_IMM; any other completed word SHALL be pushed with imm_vld=0 and imm=0.
REQ-018 In ST_IMM, the completed word SHALL become imm, the held op SHALL be pushed with imm_vld=1, and the FSM SHALL return to ST_INSTR.
REQ-019 NOP words SHALL never take an immediate.
REQ-020 A push SHALL occur on the edge that accepts the final beat; o_dcd_op_vld SHALL rise in the following cycle (1-cycle latency).
REQ-021 o_dcd_enc_rdy SHALL equal (o_dcd_cnt<DEPTH) && !i_dcd_flush && !i_dcd_rst, registered-count based only, with no combinational path from i_dcd_op_rdy; when full with a simultaneous pop, rdy stays 0 that cycle.
REQ-022 Simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-023 Pop while empty SHALL be ignored; the count SHALL never underflow or exceed DEPTH.
REQ-024 o_dcd_op SHALL be driven from registered queue storage and SHALL remain stable while vld && !rdy.
REQ-025 i_dcd_flush SHALL take priority over push and pop: the next cycle has count=0, beat counter=0, FSM=ST_INSTR, and the held op is discarded.

Reset
REQ-026 Reset SHALL set FSM=ST_INSTR, beat counter=0, queue pointers and count=0, o_dcd_op_vld=0, o_dcd_cnt=0, o_dcd_enc_rdy=0 during reset, o_dcd_op=all-zero.
REQ-027 Reset asserted mid-word or mid-immediate SHALL discard all partial state, identically to flush.

Configuration
REQ-028 Macro IDLI_DECODE_NOP_DROP_EN: when defined, nop=1 words SHALL be discarded without a push; when undefined, they SHALL be pushed with nop=1 and all other fields decoded per REQ-014.

Structure
REQ-029 idli_pkg SHALL hold dcd_op_t {opc, p, q, a, b, c, nop, imm[15:0], imm_vld}, DCD_WORD_W=16, GREG_IMM=3'd7 and the FSM enum dcd_state_t.
REQ-030 The queue SHALL be sub-module idli_dcd_fifo_m (parameter DEPTH; push/pop/flush/count).

Verification
REQ-031 LANE_W=4, beats C,1,2,3 -> one entry opc=C, p=0, a=4, b=4, c=3, q=0, imm_vld=0; vld high in the cycle after the 4th beat.
REQ-032 LANE_W=8, beats C1,27,BE,EF -> exactly one entry, c=7, imm=BEEF, imm_vld=1; no entry after beat 27.
REQ-033 DEPTH=4, op_rdy=0, push 4 words -> cnt=4, enc_rdy=0; op_rdy=1 for one cycle -> cnt=3, enc_rdy=1 in the next cycle; order preserved.
REQ-034 Word 0000: with IDLI_DECODE_NOP_DROP_EN defined -> cnt stays 0; without it -> entry nop=1, p=PT. Word 0100 -> entry nop=0, p=PT in both builds.
REQ-035 LANE_W=4: C127 followed by 2 immediate beats, then flush -> cnt=0; next word D012 -> single entry opc=D, c=2, imm_vld=0.
REQ-036 Reset asserted after 1 beat of word C123, then the full word C123 sent -> exactly one correct entry.
